// File: rtl/instr_loader.sv
// Boot loader: packs a byte stream into 9-bit words and writes them
// to instruction memory from address 0, holding the core until done.
module instr_loader #(
  parameter int D = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic         wr_en,
  output logic [D-1:0] wr_addr,
  output logic [8:0]   wr_data,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [D:0]   word_count,
  output logic         cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [D-1:0] ADDR_MAX = '1;

  state_t       state;
  logic [D-1:0] addr;
  logic [7:0]   lo_reg;
  logic         last_q;
  logic         xfer;

  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      lo_reg     <= '0;
      last_q     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LO;
            addr       <= '0;
            word_count <= '0;
            err        <= 1'b0;
          end
        end
        S_LO: begin
          if (xfer) begin
            lo_reg <= in_byte;
            if (in_last) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_HI;
            end
          end
        end
        S_HI: begin
          if (xfer) begin
            wr_data <= {in_byte[0], lo_reg};
            wr_addr <= addr;
            last_q  <= in_last;
            if (|in_byte[7:1])
              err <= 1'b1;
            state <= S_WR;
          end
        end
        S_WR: begin
          word_count <= word_count + 1'b1;
          // addr saturates at the top word; a restart clears it
          if (last_q || addr == ADDR_MAX) begin
            state <= S_DONE;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_LO;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready = (state == S_LO) || (state == S_HI);
  assign wr_en    = (state == S_WR);
  assign busy     = in_ready | wr_en;
  assign done     = (state == S_DONE);
  assign cpu_hold = !done;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader (D=2) against a stream-level
// model of which bytes are taken and which words land where.
module tb_instr_loader;

  localparam int D = 2;
  localparam int DEPTH = 1 << D;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [7:0]   in_byte;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         wr_en;
  logic [D-1:0] wr_addr;
  logic [8:0]   wr_data;
  logic         busy;
  logic         done;
  logic         err;
  logic [D:0]   word_count;
  logic         cpu_hold;

  instr_loader #(.D(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .word_count (word_count),
    .cpu_hold   (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [D-1:0] a;
    logic [8:0]   d;
  } wr_t;

  int vectors = 0;
  int errors = 0;

  wr_t        got[$];
  wr_t        exp_w[$];
  logic [8:0] stim[$];
  logic       exp_err;
  int         exp_wc;
  int         exp_nacc;

  always @(negedge clk)
    if (wr_en) got.push_back('{a: wr_addr, d: wr_data});

  // Walk the stream as byte pairs; stop at a last flag or a full memory.
  function automatic void run_model();
    logic [8:0] lo, hi;
    int i = 0;
    exp_w.delete();
    exp_err = 1'b0;
    exp_wc = 0;
    exp_nacc = 0;
    while (i < stim.size()) begin
      lo = stim[i];
      exp_nacc++;
      if (lo[8]) begin
        exp_err = 1'b1;
        return;
      end
      if (i + 1 >= stim.size()) return;
      hi = stim[i+1];
      exp_nacc++;
      exp_w.push_back('{a: exp_wc[D-1:0], d: {hi[0], lo[7:0]}});
      if (hi[7:1] != 7'd0) exp_err = 1'b1;
      exp_wc++;
      i += 2;
      if (hi[8] || exp_wc == DEPTH) return;
    end
  endfunction

  task automatic send_byte(input logic [8:0] b);
    int n = 0;
    in_byte = b[7:0];
    in_last = b[8];
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic load_and_check(input string name, input int maxgap,
                                input bit mid_start);
    got.delete();
    run_model();
    pulse_start();
    vectors++;
    if (busy !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b1) begin
      errors++;
      $display("FAIL %s start: busy=%b err=%b hold=%b required 1 0 1",
               name, busy, err, cpu_hold);
    end
    for (int k = 0; k < exp_nacc; k++) begin
      repeat ($urandom_range(0, maxgap)) @(negedge clk);
      if (mid_start && k == 2) pulse_start();
      send_byte(stim[k]);
    end
    wait_done();
    vectors++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done: done=%b hold=%b busy=%b required 1 0 0",
               name, done, cpu_hold, busy);
    end
    vectors++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b required %b", name, err, exp_err);
    end
    vectors++;
    if (word_count !== (D+1)'(exp_wc)) begin
      errors++;
      $display("FAIL %s word_count: got %0d required %0d",
               name, word_count, exp_wc);
    end
    vectors++;
    if (got.size() != exp_w.size()) begin
      errors++;
      $display("FAIL %s nwrites: got %0d required %0d",
               name, got.size(), exp_w.size());
    end
    for (int k = 0; k < exp_w.size() && k < got.size(); k++) begin
      vectors++;
      if (got[k] !== exp_w[k]) begin
        errors++;
        $display("FAIL %s write%0d: got a=%0d d=%h required a=%0d d=%h",
                 name, k, got[k].a, got[k].d, exp_w[k].a, exp_w[k].d);
      end
    end
    if (exp_w.size() > 0) begin
      vectors++;
      if ({wr_addr, wr_data} !== exp_w[exp_w.size()-1]) begin
        errors++;
        $display("FAIL %s hold: got a=%0d d=%h required a=%0d d=%h", name,
                 wr_addr, wr_data, exp_w[exp_w.size()-1].a,
                 exp_w[exp_w.size()-1].d);
      end
    end
    if (stim.size() > exp_nacc) begin
      in_byte = stim[exp_nacc][7:0];
      in_valid = 1'b1;
      repeat (4) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s extra_ready: got %b required 0", name, in_ready);
        end
        @(negedge clk);
      end
      in_valid = 1'b0;
      vectors++;
      if (got.size() != exp_w.size() || done !== 1'b1) begin
        errors++;
        $display("FAIL %s extra_write: nwr=%0d done=%b required %0d 1",
                 name, got.size(), done, exp_w.size());
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    vectors++;
    if ({in_ready, wr_en, wr_addr, wr_data, busy, done, err, word_count,
         cpu_hold} !== {1'b0, 1'b0, {D{1'b0}}, 9'd0, 1'b0, 1'b0, 1'b0,
                        {(D+1){1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL %s: rdy=%b wen=%b a=%0d d=%h bsy=%b dn=%b e=%b wc=%0d h=%b required reset values",
               name, in_ready, wr_en, wr_addr, wr_data, busy, done, err,
               word_count, cpu_hold);
    end
  endtask

  task automatic test_reset();
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("idle");
  endtask

  task automatic test_basic();
    stim = '{9'h07E, 9'h000, 9'h0DE, 9'h101};
    load_and_check("basic", 0, 1'b0);
  endtask

  task automatic test_stall();
    got.delete();
    pulse_start();
    send_byte(9'h055);
    repeat (5) begin
      vectors++;
      if (in_ready !== 1'b1 || wr_en !== 1'b0) begin
        errors++;
        $display("FAIL stall: rdy=%b wen=%b required 1 0", in_ready, wr_en);
      end
      @(negedge clk);
    end
    send_byte(9'h101);
    vectors++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, {D{1'b0}}, 9'h155}) begin
      errors++;
      $display("FAIL stall_write: wen=%b a=%0d d=%h required 1 0 155",
               wr_en, wr_addr, wr_data);
    end
    @(negedge clk);
    vectors++;
    if (wr_en !== 1'b0 || done !== 1'b1 || word_count !== 3'd1) begin
      errors++;
      $display("FAIL stall_done: wen=%b done=%b wc=%0d required 0 1 1",
               wr_en, done, word_count);
    end
  endtask

  task automatic test_hi_err();
    stim = '{9'h012, 9'h103};
    load_and_check("hi_err", 1, 1'b0);
    stim = '{9'h0AA, 9'h000, 9'h034, 9'h101};
    load_and_check("err_clear", 1, 1'b0);
  endtask

  task automatic test_last_lo();
    stim = '{9'h011, 9'h000, 9'h122, 9'h001};
    load_and_check("last_lo", 1, 1'b0);
  endtask

  task automatic test_full();
    stim.delete();
    for (int w = 0; w < 5; w++) begin
      stim.push_back({1'b0, 8'(w * 16 + 3)});
      stim.push_back({w == 4, 8'(w & 1)});
    end
    load_and_check("full", 2, 1'b0);
  endtask

  task automatic test_start_busy();
    stim = '{9'h021, 9'h001, 9'h043, 9'h000, 9'h065, 9'h101};
    load_and_check("start_busy", 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    stim = '{9'h001, 9'h000, 9'h002, 9'h000, 9'h003, 9'h101};
    got.delete();
    pulse_start();
    for (int k = 0; k < 5; k++) send_byte(stim[k]);
    #3 rst_n = 1'b0;
    #1 check_reset_vals("reset_mid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stim = '{9'h0F0, 9'h001, 9'h00F, 9'h100};
    load_and_check("reload", 1, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] hi;
    int nw, lo_last;
    for (int it = 0; it < 25; it++) begin
      stim.delete();
      nw = $urandom_range(1, 6);
      lo_last = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nw - 1) : -1;
      for (int w = 0; w < nw; w++) begin
        hi = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                                         : 8'($urandom_range(0, 1));
        stim.push_back({w == lo_last, 8'($urandom)});
        stim.push_back({w == nw - 1, hi});
      end
      load_and_check("rand", 3, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_byte = 8'd0;
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_hi_err();
    test_last_lo();
    test_full();
    test_start_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time loader that fills the writable instruction memory with 9-bit machine code before the core runs. Accepts a byte stream over a valid/ready handshake, packs each pair of bytes into one 9-bit instruction, and writes the words to consecutive addresses starting at 0. Holds the core in reset until a load completes. Sits between the host or UART byte source and the instruction memory write port; the program counter drives the memory's read port.

## Interface
- D, 12, instruction memory address width; memory depth is 2**D words
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a load; honoured only in IDLE or DONE
- in_byte  in  8  stream data byte
- in_valid  in  1  in_byte/in_last valid this cycle
- in_last  in  1  marks the final byte (the high byte of the final word)
- in_ready  out  1  loader accepts a byte this cycle
- wr_en  out  1  instruction memory write strobe
- wr_addr  out  D  write address
- wr_data  out  9  machine-code word
- busy  out  1  load in progress (LO, HI, WR)
- done  out  1  load finished; sticky until next start
- err  out  1  sticky format error for the current load
- word_count  out  D+1  words written in the current or last load
- cpu_hold  out  1  keeps the core in reset

## Operation
- A byte transfers when in_valid & in_ready are both high on a rising clk edge.
- Word format: first byte = wr_data[7:0]; second byte bit0 = wr_data[8]; second byte bits[7:1] must be 0.
- States:
  - IDLE: in_ready=0. start -> LO; clear addr, word_count, err, done.
  - LO: in_ready=1. On a transfer, latch in_byte -> HI. If in_last=1 on the low byte: set err -> DONE, no write.
  - HI: in_ready=1. On a transfer, form wr_data = {in_byte[0], lo_reg}. If in_byte[7:1] != 0, set err; the word is still written. Capture in_last -> WR.
  - WR: wr_en=1 and wr_addr=addr for exactly one cycle. Then increment addr and word_count. Go to DONE if the captured last was set or addr == 2**D-1; otherwise go to LO.
  - DONE: done=1, cpu_hold=0, in_ready=0. start -> LO with the same clears as IDLE.
- start while busy is ignored.
- Bytes that arrive in IDLE or DONE are not accepted (in_ready=0).
- Address-space full: after the write to 2**D-1, go to DONE with word_count = 2**D. Do not wrap, and set no err. Further bytes remain unaccepted.
- cpu_hold is 1 from reset until the first entry to DONE. It returns to 1 whenever a new load starts.
- wr_data and wr_addr hold their last values when wr_en=0.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0
  - busy=0, done=0, err=0, word_count=0
  - cpu_hold=1
- Reset mid-load aborts immediately to the reset values. Words already written stay in memory.
- in_ready and all status outputs are registered-state decodes; there is no combinational path from in_valid to in_ready.
- wr_en asserts in the cycle after the high-byte transfer.
- A word takes at least 3 cycles, so sustained throughput is 2 bytes per 3 cycles.
- word_count updates on the edge that ends WR.
- done and cpu_hold=0 take effect in the cycle after the final WR.
- busy rises in the cycle after start is sampled.

## Test plan
- Reset, then start. Stream 7E,00 | DE,01 (last). Required: wr_en at addr 0 with data 0x07E, then at addr 1 with data 0x1DE. Then done=1, word_count=2, err=0, cpu_hold=0.
- Hold in_valid low for 5 cycles between the low and high byte. Required: loader waits in HI with in_ready=1, and one correct write follows.
- High byte 0x03. Required: wr_data=0x1xx is written and err=1 stays set through DONE. A subsequent start clears err.
- in_last on a low byte. Required: no write, DONE with err=1, word_count unchanged.
- D=2 with 5 words streamed. Required: 4 writes to addrs 0..3, then done=1, word_count=4, 5th word not accepted (in_ready=0).
- Assert rst_n low during HI of word 3. Required: all outputs return to reset values asynchronously with cpu_hold=1. A new start reloads from addr 0.
